// File: rtl/parking_bay_manager.sv
// N-spot parking bay controller: per-spot occupancy FSMs with seconds timers,
// overtime fines, free-space count, entry gate and a scanning display feed.
module parking_bay_manager #(
    parameter int N_SPOTS   = 3,
    parameter int TICK_DIV  = 4,
    parameter int LIMIT_SEC = 10,
    parameter int SEC_W     = 6,
    localparam int CNT_W    = $clog2(N_SPOTS + 1),
    localparam int IDX_W    = (N_SPOTS > 1) ? $clog2(N_SPOTS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SPOTS-1:0] occ,
    input  logic               entry_req,
    output logic               entry_grant,
    output logic               green,
    output logic               full,
    output logic [CNT_W-1:0]   free_count,
    output logic [N_SPOTS-1:0] penalty,
    output logic               fine_valid,
    output logic [IDX_W-1:0]   fine_spot,
    output logic [SEC_W-1:0]   fine_amount,
    output logic [IDX_W-1:0]   disp_idx,
    output logic [SEC_W-1:0]   disp_sec,
    output logic               sec_tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [SEC_W-1:0] LIMIT = SEC_W'(LIMIT_SEC);
    localparam logic [SEC_W-1:0] SEC_MAX = '1;

    typedef enum logic [1:0] {FREE, PARKED, PENALTY} state_t;

    state_t             st   [N_SPOTS];
    logic [SEC_W-1:0]   sec  [N_SPOTS];
    logic [SEC_W-1:0]   amt  [N_SPOTS];
    logic [N_SPOTS-1:0] pend;
    logic [N_SPOTS-1:0] occ_q;
    logic [DIV_W-1:0]   div;
    logic               armed;
    logic               sel_hit;
    logic [IDX_W-1:0]   sel;

    assign sec_tick = (div == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            div      <= '0;
            disp_idx <= '0;
        end else begin
            div <= sec_tick ? '0 : div + 1'b1;
            if (sec_tick)
                disp_idx <= (disp_idx == IDX_W'(N_SPOTS - 1)) ? '0 : disp_idx + 1'b1;
        end
    end

    // Lowest-index pending fine wins the output slot this cycle
    always_comb begin
        sel_hit = 1'b0;
        sel     = '0;
        for (int i = N_SPOTS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_hit = 1'b1;
                sel     = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occ_q       <= '0;
            pend        <= '0;
            fine_valid  <= 1'b0;
            fine_spot   <= '0;
            fine_amount <= '0;
            for (int i = 0; i < N_SPOTS; i++) begin
                st[i]  <= FREE;
                sec[i] <= '0;
                amt[i] <= '0;
            end
        end else begin
            occ_q       <= occ;
            fine_valid  <= sel_hit;
            fine_spot   <= sel;
            fine_amount <= sel_hit ? amt[sel] : '0;
            if (sel_hit)
                pend[sel] <= 1'b0;
            for (int i = 0; i < N_SPOTS; i++) begin
                case (st[i])
                    FREE: begin
                        if (occ_q[i]) begin
                            st[i]  <= PARKED;
                            sec[i] <= '0;
                        end
                    end
                    PARKED: begin
                        if (!occ_q[i]) begin
                            st[i] <= FREE;
                        end else if (sec_tick) begin
                            sec[i] <= sec[i] + 1'b1;
                            if (sec[i] == LIMIT - 1'b1)
                                st[i] <= PENALTY;
                        end
                    end
                    PENALTY: begin
                        if (!occ_q[i]) begin
                            st[i]   <= FREE;
                            pend[i] <= 1'b1;
                            amt[i]  <= sec[i] - LIMIT;
                        end else if (sec_tick && sec[i] != SEC_MAX) begin
                            sec[i] <= sec[i] + 1'b1;
                        end
                    end
                    default: st[i] <= FREE;
                endcase
            end
        end
    end

    always_comb begin
        free_count = '0;
        penalty    = '0;
        for (int i = 0; i < N_SPOTS; i++) begin
            if (st[i] == FREE)
                free_count = free_count + CNT_W'(1);
            penalty[i] = (st[i] == PENALTY);
        end
    end

    assign full     = (free_count == '0);
    assign green    = ~full;
    assign disp_sec = (st[disp_idx] == FREE) ? '0 : sec[disp_idx];

    // One grant per request: re-armed only once entry_req is seen low
    always_ff @(posedge clk) begin
        if (!reset) begin
            entry_grant <= 1'b0;
            armed       <= 1'b1;
        end else begin
            entry_grant <= 1'b0;
            if (!entry_req) begin
                armed <= 1'b1;
            end else if (armed && !full) begin
                entry_grant <= 1'b1;
                armed       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parking_bay_manager.sv
// Self-checking bench for parking_bay_manager with a fine scoreboard queue.
module tb_parking_bay_manager;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] occ = '0;
    logic         entry_req = 1'b0;
    logic         entry_grant, green, full, fine_valid, sec_tick;
    logic [1:0]   free_count, fine_spot, disp_idx;
    logic [N-1:0] penalty;
    logic [5:0]   fine_amount, disp_sec;

    typedef struct {
        int spot;
        int amt;
    } fine_t;

    fine_t fq[$];
    int checks = 0;
    int errors = 0;
    int grants = 0;
    int fines  = 0;

    parking_bay_manager dut (
        .clk(clk), .reset(reset), .occ(occ), .entry_req(entry_req),
        .entry_grant(entry_grant), .green(green), .full(full),
        .free_count(free_count), .penalty(penalty),
        .fine_valid(fine_valid), .fine_spot(fine_spot),
        .fine_amount(fine_amount), .disp_idx(disp_idx),
        .disp_sec(disp_sec), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Returns just after the edge that consumes the n-th observed tick
    task automatic wait_ticks(input int n);
        for (int t = 0; t < n; t++) begin
            int k = 0;
            @(negedge clk);
            while (!sec_tick && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (k >= 20) check("tick_timeout", 0, 1);
            @(posedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (entry_grant) grants++;
        if (fine_valid) begin
            fines++;
            if (fq.size() == 0) begin
                check("fine_unexpected", 1, 0);
            end else begin
                fine_t e;
                e = fq.pop_front();
                check("fine_spot", fine_spot, e.spot);
                check("fine_amount", fine_amount, e.amt);
            end
        end
    end

    initial begin
        int g0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_free", free_count, 3);
        check("rst_green", green, 1);
        check("rst_full", full, 0);
        check("rst_pen", penalty, 0);
        check("rst_fv", fine_valid, 0);
        check("rst_fspot", fine_spot, 0);
        check("rst_famt", fine_amount, 0);
        check("rst_grant", entry_grant, 0);
        check("rst_tick", sec_tick, 0);
        check("rst_didx", disp_idx, 0);
        check("rst_dsec", disp_sec, 0);
        reset = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("tick_phase", sec_tick, (c % 4) == 3);
            check("disp_scan", disp_idx, c / 4);
        end
        wait_ticks(1);
        @(negedge clk);
        check("disp_wrap", disp_idx, 0);

        // Single car overstays by three seconds
        occ = 3'b001;
        @(posedge clk);
        @(posedge clk);
        wait_ticks(9);
        @(negedge clk);
        check("pen_before", penalty, 0);
        check("free_one_parked", free_count, 2);
        wait_ticks(1);
        @(negedge clk);
        check("pen_after10", penalty, 3'b001);
        wait_ticks(3);
        @(negedge clk);
        occ = 3'b000;
        fq.push_back('{0, 3});
        repeat (5) @(negedge clk);
        check("free_after_dep", free_count, 3);
        check("pen_cleared", penalty, 0);

        // Full bay blocks the gate; a fresh request gets one grant
        occ = 3'b111;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("full_free", free_count, 0);
        check("full_flag", full, 1);
        check("full_green", green, 0);
        g0 = grants;
        entry_req = 1'b1;
        repeat (5) @(negedge clk);
        check("no_grant_full", grants - g0, 0);
        entry_req = 1'b0;
        occ = 3'b101;
        repeat (3) @(negedge clk);
        check("free_one", free_count, 1);
        check("green_one", green, 1);
        g0 = grants;
        entry_req = 1'b1;
        @(negedge clk);
        check("grant_latency", entry_grant, 1);
        repeat (5) @(negedge clk);
        check("grant_once", grants - g0, 1);
        entry_req = 1'b0;
        occ = 3'b000;
        repeat (4) @(negedge clk);
        check("free_reset3", free_count, 3);

        // Two penalised spots leave together
        occ = 3'b001;
        @(posedge clk);
        @(posedge clk);
        wait_ticks(2);
        @(negedge clk);
        occ = 3'b101;
        @(posedge clk);
        @(posedge clk);
        wait_ticks(13);
        @(negedge clk);
        check("pen_both", penalty, 3'b101);
        occ = 3'b000;
        fq.push_back('{0, 5});
        fq.push_back('{2, 3});
        @(negedge clk);
        @(negedge clk);
        check("fv_not_yet", fine_valid, 0);
        @(negedge clk);
        check("fv_first", fine_valid, 1);
        @(negedge clk);
        check("fv_second", fine_valid, 1);
        @(negedge clk);
        check("fv_done", fine_valid, 0);

        // Departure coincides with a tick: no extra second charged
        occ = 3'b001;
        @(posedge clk);
        @(posedge clk);
        wait_ticks(12);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        occ = 3'b000;
        fq.push_back('{0, 2});
        @(negedge clk);
        check("coinc_tick", sec_tick, 1);
        check("coinc_pen", penalty, 3'b001);
        @(negedge clk);
        check("coinc_free", free_count, 3);
        repeat (4) @(negedge clk);

        // Reset while a fine is pending discards it
        occ = 3'b010;
        @(posedge clk);
        @(posedge clk);
        wait_ticks(11);
        @(negedge clk);
        check("pen_spot1", penalty, 3'b010);
        occ = 3'b000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("rr_free", free_count, 3);
        check("rr_pen", penalty, 0);
        check("rr_fv", fine_valid, 0);
        check("rr_didx", disp_idx, 0);
        check("rr_tick", sec_tick, 0);
        check("rr_dsec", disp_sec, 0);
        repeat (10) @(negedge clk);

        check("fine_count", fines, 4);
        check("fine_q_empty", fq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
